// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: single-port RAM with a command decoder, placed directly
// behind the SPI slave. Each 10-bit word from the slave carries a 2-bit
// opcode and an 8-bit payload:
//    00 write address, 01 write data, 10 read address, 11 read data.
// Read bytes go back to the slave on dout/tx_valid for shifting onto MISO.
//
// Ports:
//    clk       system clock, rising edge
//    rst       synchronous, active-high reset
//    din       [9:8] opcode, [7:0] payload
//    rx_valid  din valid, one pulse per command
//    dout      read byte, held until the next read completes
//    tx_valid  one-cycle pulse per returned byte
//    cmd_err   one-cycle pulse per rejected command (data/read before address)
//
// FSM states:
//    state  | meaning
//    IDLE   | no read byte being presented
//    RD_OUT | dout holds a fresh byte, tx_valid high this cycle
module spi_ram_ctrl #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8,
   parameter int AUTO_INC  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] din,
   input  logic       rx_valid,
   output logic [7:0] dout,
   output logic       tx_valid,
   output logic       cmd_err
);

   typedef enum logic {IDLE, RD_OUT} state_t;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   state_t state, state_nxt;

   logic [7:0]           mem [MEM_DEPTH];
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic                 wr_addr_set;
   logic                 rd_addr_set;

   logic [1:0] opcode;
   logic       wr_data_ok;
   logic       rd_data_ok;
   logic       reject;

   assign opcode     = din[9:8];
   assign wr_data_ok = rx_valid && (opcode == OP_WR_DATA) && wr_addr_set;
   assign rd_data_ok = rx_valid && (opcode == OP_RD_DATA) && rd_addr_set;
   assign reject     = rx_valid &&
                       (((opcode == OP_WR_DATA) && !wr_addr_set) ||
                        ((opcode == OP_RD_DATA) && !rd_addr_set));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: an accepted read-data always lands in RD_OUT, so back-to-back
   // reads keep tx_valid high with one byte per command.
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = rd_data_ok ? RD_OUT : IDLE;
         RD_OUT:  state_nxt = rd_data_ok ? RD_OUT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      tx_valid = 1'b0;
      case (state)
         RD_OUT:  tx_valid = 1'b1;
         default: tx_valid = 1'b0;
      endcase
   end

   // RAM array: not cleared by reset, but a write coinciding with reset is
   // dropped because reset wins over any command.
   always_ff @(posedge clk) begin
      if (!rst && wr_data_ok) begin
         mem[wr_addr] <= din[7:0];
      end
   end

   // Address registers, flags, read data and error pulse.
   // Wrap on increment is implicit because MEM_DEPTH == 2**ADDR_SIZE.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr     <= '0;
         rd_addr     <= '0;
         wr_addr_set <= 1'b0;
         rd_addr_set <= 1'b0;
         dout        <= 8'h00;
         cmd_err     <= 1'b0;
      end else begin
         cmd_err <= reject;
         if (rx_valid) begin
            case (opcode)
               OP_WR_ADDR: begin
                  wr_addr     <= din[ADDR_SIZE-1:0];
                  wr_addr_set <= 1'b1;
               end
               OP_WR_DATA: begin
                  if (wr_addr_set && (AUTO_INC != 0)) begin
                     wr_addr <= wr_addr + ADDR_SIZE'(1);
                  end
               end
               OP_RD_ADDR: begin
                  rd_addr     <= din[ADDR_SIZE-1:0];
                  rd_addr_set <= 1'b1;
               end
               OP_RD_DATA: begin
                  if (rd_addr_set) begin
                     dout <= mem[rd_addr];
                     if (AUTO_INC != 0) begin
                        rd_addr <= rd_addr + ADDR_SIZE'(1);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: two instances (AUTO_INC=0 and AUTO_INC=1) share a
// clock. Stimulus pushes expected responses (kind, byte, due cycle) into a
// per-instance queue; a negedge monitor pops and compares whenever an
// instance raises tx_valid or cmd_err, and also services point probes.
module tb_spi_ram_ctrl;

   typedef struct {
      logic       is_err;
      logic [7:0] data;
      int         due;
   } exp_t;

   localparam int K_NONE = 0;
   localparam int K_DATA = 1;
   localparam int K_ERR  = 2;

   logic       clk = 1'b0;
   logic       rst0, rst1;
   logic       rx_valid0, rx_valid1;
   logic [9:0] din0, din1;
   logic [7:0] dout0, dout1;
   logic       tx0, tx1;
   logic       err0, err1;

   always #5 clk = ~clk;

   spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) u_dut0 (
      .clk(clk), .rst(rst0), .din(din0), .rx_valid(rx_valid0),
      .dout(dout0), .tx_valid(tx0), .cmd_err(err0)
   );

   spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) u_dut1 (
      .clk(clk), .rst(rst1), .din(din1), .rx_valid(rx_valid1),
      .dout(dout1), .tx_valid(tx1), .cmd_err(err1)
   );

   exp_t  q [2][$];
   int    n_assert = 0;
   int    n_fail   = 0;
   int    cyc      = 0;

   int         probe_seq  = 0;
   int         probe_seen = 0;
   int         probe_dut  = 0;
   logic       probe_tx   = 1'b0;
   logic       probe_err  = 1'b0;
   logic [7:0] probe_dout = 8'h00;
   string      probe_name = "";

   bit final_req = 1'b0;
   bit done      = 1'b0;

   // ---------------- monitor ----------------
   task automatic check_dut(input int d, input logic r, input logic t,
                            input logic e, input logic [7:0] dv);
      exp_t x;
      if (r) return;
      while (q[d].size() > 0 && q[d][0].due < cyc) begin
         x = q[d].pop_front();
         n_assert++;
         n_fail++;
         $display("FAIL missing_resp dut%0d: nothing seen at cycle %0d, want err=%0b data=%02h",
                  d, x.due, x.is_err, x.data);
      end
      n_assert++;
      if (t && e) begin
         n_fail++;
         $display("FAIL overlap dut%0d: tx_valid=1 cmd_err=1 at cycle %0d, want not both", d, cyc);
      end
      if (t) begin
         n_assert++;
         if (q[d].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_tx dut%0d: dout=%02h at cycle %0d, want no tx_valid", d, dv, cyc);
         end else begin
            x = q[d].pop_front();
            if (x.is_err || x.data !== dv || x.due != cyc) begin
               n_fail++;
               $display("FAIL read_data dut%0d: got dout=%02h at cycle %0d, want err=%0b data=%02h at cycle %0d",
                        d, dv, cyc, x.is_err, x.data, x.due);
            end
         end
      end
      if (e) begin
         n_assert++;
         if (q[d].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_err dut%0d: cmd_err=1 at cycle %0d, want no error", d, cyc);
         end else begin
            x = q[d].pop_front();
            if (!x.is_err || x.due != cyc) begin
               n_fail++;
               $display("FAIL cmd_err dut%0d: got cmd_err at cycle %0d, want err=%0b data=%02h at cycle %0d",
                        d, cyc, x.is_err, x.data, x.due);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (probe_seq != probe_seen) begin
         logic       pt, pe;
         logic [7:0] pd;
         probe_seen = probe_seq;
         pt = (probe_dut == 0) ? tx0   : tx1;
         pe = (probe_dut == 0) ? err0  : err1;
         pd = (probe_dut == 0) ? dout0 : dout1;
         n_assert++;
         if (pt !== probe_tx || pe !== probe_err || pd !== probe_dout) begin
            n_fail++;
            $display("FAIL %s dut%0d: got tx=%0b err=%0b dout=%02h, want tx=%0b err=%0b dout=%02h",
                     probe_name, probe_dut, pt, pe, pd, probe_tx, probe_err, probe_dout);
         end
      end
      check_dut(0, rst0, tx0, err0, dout0);
      check_dut(1, rst1, tx1, err1, dout1);
      if (final_req && !done) begin
         for (int d = 0; d < 2; d++) begin
            n_assert++;
            if (q[d].size() != 0) begin
               n_fail++;
               $display("FAIL drain dut%0d: %0d responses outstanding, want 0", d, q[d].size());
            end
         end
         done = 1'b1;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cmd(input int d, input logic [9:0] w, input int kind,
                      input logic [7:0] ev);
      exp_t x;
      if (d == 0) begin
         din0 = w; rx_valid0 = 1'b1;
      end else begin
         din1 = w; rx_valid1 = 1'b1;
      end
      if (kind != K_NONE) begin
         x.is_err = (kind == K_ERR);
         x.data   = (kind == K_ERR) ? 8'h00 : ev;
         x.due    = cyc + 2;
         q[d].push_back(x);
      end
      @(posedge clk);
      #1;
      rx_valid0 = 1'b0;
      rx_valid1 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int d);
      if (d == 0) rst0 = 1'b1; else rst1 = 1'b1;
      @(posedge clk);
      #1;
      rst0 = 1'b0;
      rst1 = 1'b0;
   endtask

   task automatic probe(input int d, input logic t, input logic e,
                        input logic [7:0] dv, input string name);
      probe_dut  = d;
      probe_tx   = t;
      probe_err  = e;
      probe_dout = dv;
      probe_name = name;
      probe_seq++;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst0 = 1'b1; rst1 = 1'b1;
      rx_valid0 = 1'b0; rx_valid1 = 1'b0;
      din0 = '0; din1 = '0;
      @(posedge clk);
      #1;

      // ---- instance 0, AUTO_INC = 0 ----
      do_reset(0);
      probe(0, 1'b0, 1'b0, 8'h00, "reset_state");
      idle(1);

      cmd(0, 10'h300, K_ERR, 8'h00);
      probe(0, 1'b0, 1'b1, 8'h00, "rd_before_addr");
      idle(2);

      cmd(0, 10'h0A5, K_NONE, 8'h00);
      cmd(0, 10'h13C, K_NONE, 8'h00);
      cmd(0, 10'h2A5, K_NONE, 8'h00);
      cmd(0, 10'h300, K_DATA, 8'h3C);
      probe(0, 1'b1, 1'b0, 8'h3C, "basic_read");
      idle(2);
      probe(0, 1'b0, 1'b0, 8'h3C, "dout_hold");
      idle(1);

      // Put a known byte at 0x00, reset, then a write-data without address
      // must be rejected and leave 0x77 in place.
      cmd(0, 10'h000, K_NONE, 8'h00);
      cmd(0, 10'h177, K_NONE, 8'h00);
      do_reset(0);
      cmd(0, 10'h155, K_ERR, 8'h00);
      cmd(0, 10'h200, K_NONE, 8'h00);
      cmd(0, 10'h300, K_DATA, 8'h77);
      idle(2);

      // Write then read same address on consecutive cycles, then a second
      // back-to-back read of the same address.
      cmd(0, 10'h010, K_NONE, 8'h00);
      cmd(0, 10'h210, K_NONE, 8'h00);
      cmd(0, 10'h15A, K_NONE, 8'h00);
      cmd(0, 10'h300, K_DATA, 8'h5A);
      cmd(0, 10'h300, K_DATA, 8'h5A);
      idle(2);

      // Reset lands on the edge that would accept the read.
      rst0 = 1'b1; din0 = 10'h300; rx_valid0 = 1'b1;
      @(posedge clk);
      #1;
      rst0 = 1'b0; rx_valid0 = 1'b0;
      probe(0, 1'b0, 1'b0, 8'h00, "rst_mid_op");
      idle(1);
      cmd(0, 10'h300, K_ERR, 8'h00);
      cmd(0, 10'h2A5, K_NONE, 8'h00);
      cmd(0, 10'h300, K_DATA, 8'h3C);
      idle(2);

      // ---- instance 1, AUTO_INC = 1 ----
      do_reset(1);
      probe(1, 1'b0, 1'b0, 8'h00, "reset_state_inc");
      idle(1);
      cmd(1, 10'h0FF, K_NONE, 8'h00);
      cmd(1, 10'h111, K_NONE, 8'h00);
      cmd(1, 10'h122, K_NONE, 8'h00);
      cmd(1, 10'h2FF, K_NONE, 8'h00);
      cmd(1, 10'h300, K_DATA, 8'h11);
      probe(1, 1'b1, 1'b0, 8'h11, "inc_first");
      cmd(1, 10'h300, K_DATA, 8'h22);
      probe(1, 1'b1, 1'b0, 8'h22, "inc_second");
      idle(1);
      probe(1, 1'b0, 1'b0, 8'h22, "inc_tx_drop");
      idle(1);
      cmd(1, 10'h200, K_NONE, 8'h00);
      cmd(1, 10'h300, K_DATA, 8'h22);
      idle(3);

      final_req = 1'b1;
      for (int i = 0; i < 10 && !done; i++) @(posedge clk);
      if (!done) begin
         $display("FAIL drain_timeout: monitor did not finish, want done");
         $fatal(1, "drain timeout");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
